// File: rtl/sbox_pipe_array.sv
// sbox_pipe_array
//   Pipelined array of AES S-box lanes. Each transaction carries NUM_LANES
//   bytes and a mode bit. Mode 0 gives forward SubBytes and mode 1 gives
//   InvSubBytes. The byte datapath uses the composite field GF((2^4)^2):
//   an isomorphic map, then inversion, then the inverse map, with the affine
//   transform applied on the appropriate side for the selected mode.
//   The pipeline has PIPE_STAGES slots. All slots shift together when the last
//   slot is empty or downstream accepts, and all slots hold otherwise.
//
// Ports
//   clk_in     system clock, rising edge
//   rst_n_in   asynchronous active-low reset
//   in_valid   input transaction valid
//   in_ready   pipeline accepts input this cycle (combinational)
//   in_inv     0 = forward S-box, 1 = inverse S-box
//   in_data    lane k = in_data[8k+7:8k]
//   out_valid  output transaction valid
//   out_ready  downstream accepts output
//   out_data   lane k = S(byte k) or S^-1(byte k)
//   out_inv    mode tag of the transaction on out_data
module sbox_pipe_array #(
  parameter int NUM_LANES   = 16,
  parameter int PIPE_STAGES = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [8*NUM_LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_LANES-1:0] out_data,
  output logic                   out_inv
);

  if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
    $error("sbox_pipe_array: NUM_LANES=%0d outside 1..16", NUM_LANES);
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("sbox_pipe_array: PIPE_STAGES=%0d outside 1..4", PIPE_STAGES);
  end

  // Each lane occupies 12 bits inside a slot. The widest intermediate value is
  // {d^-1, ah, al}, which is held after the GF(2^4) inversion cut.
  localparam int LW = 12 * NUM_LANES;

  // GF(2^4) arithmetic, modulo x^4 + x + 1
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'b0011 : 4'b0000);
    end
    return p;
  endfunction

  // a^14 = a^-1. This also maps 0 to 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  // Returns the first lambda for which y^2 + y + lambda has no root in
  // GF(2^4). That makes y^2 + y + lambda irreducible, so it can serve as the
  // extension polynomial.
  function automatic logic [3:0] find_lambda();
    logic [3:0] lam;
    logic       found;
    logic       root;
    lam   = 4'h0;
    found = 1'b0;
    for (int l = 1; l < 16; l++) begin
      root = 1'b0;
      for (int z = 0; z < 16; z++) begin
        if ((gf16_mul(z[3:0], z[3:0]) ^ z[3:0]) == l[3:0]) root = 1'b1;
      end
      if (!root && !found) begin
        lam   = l[3:0];
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  // Composite-field multiply. An element is {ah, al}, meaning ah*y + al,
  // with y^2 = y + lambda.
  function automatic logic [7:0] comp_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] lam);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, lam) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // Finds a composite-field root beta of the AES polynomial
  // x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] find_beta(input logic [3:0] lam);
    logic [7:0] beta, p1, p2, p3, p4, p8;
    logic       found;
    beta  = 8'h00;
    found = 1'b0;
    for (int c = 1; c < 256; c++) begin
      p1 = c[7:0];
      p2 = comp_mul(p1, p1, lam);
      p3 = comp_mul(p2, p1, lam);
      p4 = comp_mul(p2, p2, lam);
      p8 = comp_mul(p4, p4, lam);
      if (((p8 ^ p4 ^ p3 ^ p1 ^ 8'h01) == 8'h00) && !found) begin
        beta  = p1;
        found = 1'b1;
      end
    end
    return beta;
  endfunction

  // Applies an 8x8 GF(2) matrix. Column i is held in m[8i+7:8i].
  function automatic logic [7:0] apply_mat(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) r = r ^ m[8*i +: 8];
    end
    return r;
  endfunction

  // Isomorphism from GF(2^8) to the composite field. Column i is beta^i.
  function automatic logic [63:0] iso_cols(input logic [3:0] lam);
    logic [63:0] m;
    logic [7:0]  beta, pw;
    beta = find_beta(lam);
    pw   = 8'h01;
    m    = 64'h0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = pw;
      pw = comp_mul(pw, beta, lam);
    end
    return m;
  endfunction

  // Inverse map. Column j is the GF(2^8) byte whose image is unit vector j.
  function automatic logic [63:0] inv_cols(input logic [63:0] m);
    logic [63:0] r;
    logic [7:0]  v, unit;
    r = 64'h0;
    for (int a = 0; a < 256; a++) begin
      v = apply_mat(m, a[7:0]);
      for (int j = 0; j < 8; j++) begin
        unit = 8'h01 << j;
        if (v == unit) r[8*j +: 8] = a[7:0];
      end
    end
    return r;
  endfunction

  localparam logic [3:0]  LAMBDA    = find_lambda();
  localparam logic [63:0] ISO_M     = iso_cols(LAMBDA);
  localparam logic [63:0] INV_ISO_M = inv_cols(ISO_M);

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Segment A: inverse affine (inverse mode only), then the isomorphic map.
  function automatic logic [7:0] seg_a(input logic [7:0] x, input logic inv);
    return apply_mat(ISO_M, inv ? affine_inv(x) : x);
  endfunction

  // Segment B: computes the norm d, then d^-1 in GF(2^4).
  function automatic logic [11:0] seg_b(input logic [7:0] c);
    logic [3:0] d;
    d = gf16_mul(gf16_mul(c[7:4], c[7:4]), LAMBDA) ^ gf16_mul(c[7:4], c[3:0])
        ^ gf16_mul(c[3:0], c[3:0]);
    return {gf16_inv(d), c};
  endfunction

  // Segment C: forms the inverse as d^-1 * (ah*y + ah + al), then applies the
  // inverse map back to GF(2^8).
  function automatic logic [7:0] seg_c(input logic [11:0] v);
    return apply_mat(INV_ISO_M, {gf16_mul(v[11:8], v[7:4]),
                                 gf16_mul(v[11:8], v[7:4] ^ v[3:0])});
  endfunction

  // Segment D: forward affine (forward mode only).
  function automatic logic [7:0] seg_d(input logic [7:0] x, input logic inv);
    return inv ? x : affine_fwd(x);
  endfunction

  // Datapath formats: 0 raw byte, 1 after iso_map, 2 after GF(2^4) inversion,
  // 3 after inv_iso_map, 4 final result. Slot s holds format cut_fmt(s), and
  // the last slot always holds the final result.
  function automatic int cut_fmt(input int s);
    return (s == PIPE_STAGES - 1) ? 4 : s + 1;
  endfunction

  function automatic logic [11:0] lane_step(input int in_fmt, input int out_fmt,
                                            input logic [11:0] x, input logic inv);
    logic [11:0] v;
    v = x;
    if (in_fmt < 1 && out_fmt >= 1) v = {4'h0, seg_a(v[7:0], inv)};
    if (in_fmt < 2 && out_fmt >= 2) v = seg_b(v[7:0]);
    if (in_fmt < 3 && out_fmt >= 3) v = {4'h0, seg_c(v)};
    if (in_fmt < 4 && out_fmt >= 4) v = {4'h0, seg_d(v[7:0], inv)};
    return v;
  endfunction

  logic          r_v   [PIPE_STAGES];
  logic          r_inv [PIPE_STAGES];
  logic [LW-1:0] r_d   [PIPE_STAGES];
  logic [LW-1:0] w_nxt [PIPE_STAGES];
  logic          w_advance;

  assign w_advance = out_ready || !r_v[PIPE_STAGES-1];
  assign in_ready  = w_advance;
  assign out_valid = r_v[PIPE_STAGES-1];
  assign out_inv   = r_inv[PIPE_STAGES-1];

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      out_data[8*k +: 8] = r_d[PIPE_STAGES-1][12*k +: 8];
    end
  end

  always_comb begin
    logic [11:0] src;
    logic        src_inv;
    int          ps;
    src     = 12'h0;
    src_inv = 1'b0;
    ps      = 0;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      w_nxt[s] = '0;
      ps = (s == 0) ? 0 : s - 1;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (s == 0) begin
          src     = {4'h0, in_data[8*k +: 8]};
          src_inv = in_inv;
          w_nxt[s][12*k +: 12] = lane_step(0, cut_fmt(0), src, src_inv);
        end else begin
          src     = r_d[ps][12*k +: 12];
          src_inv = r_inv[ps];
          w_nxt[s][12*k +: 12] = lane_step(cut_fmt(ps), cut_fmt(s), src, src_inv);
        end
      end
    end
  end

  // Bubbles load zeros, so out_data and out_inv read 0 whenever out_valid is 0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_v[s]   <= 1'b0;
        r_inv[s] <= 1'b0;
        r_d[s]   <= '0;
      end
    end else if (w_advance) begin
      r_v[0]   <= in_valid;
      r_inv[0] <= in_valid && in_inv;
      r_d[0]   <= in_valid ? w_nxt[0] : '0;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_v[s]   <= r_v[s-1];
        r_inv[s] <= r_v[s-1] && r_inv[s-1];
        r_d[s]   <= r_v[s-1] ? w_nxt[s] : '0;
      end
    end
  end

endmodule
